// File: rtl/fpga_clk_pkg.sv
// Shared constants for the clock-ratio controller: register word offsets,
// STATUS field positions and the ratio-switch state encoding.
package fpga_clk_pkg;

  // Word offsets decoded from paddr[3:2]
  localparam logic [1:0] REG_RATIO  = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CNT    = 2'd2;

  // STATUS field positions
  localparam int ST_BUSY_BIT = 0;
  localparam int ST_CUR_LSB  = 4;
  localparam int ST_PEND_LSB = 8;
  localparam int ST_GATE_BIT = 12;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2
  } state_t;

endpackage

// File: rtl/fpga_clk_div_cnt.sv
// Period counter for the 1-in-(N+1) enable train. wrap is the enable pulse:
// counter at terminal value while running and not gated.
module fpga_clk_div_cnt #(
  parameter int RATIO_W = 3
) (
  input  logic               per_clk,
  input  logic               clkrst,
  input  logic               run,
  input  logic               gate_q,
  input  logic [RATIO_W-1:0] cur_ratio,
  output logic [RATIO_W-1:0] cnt,
  output logic               wrap
);

  logic at_term;

  assign at_term = (cnt == cur_ratio);
  assign wrap    = run & ~gate_q & at_term;

  // Count up to the ratio; restart on terminal count, on gating and outside run
  always_ff @(posedge per_clk) begin
    if (clkrst) begin
      cnt <= '0;
    end else if (!run || gate_q || at_term) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fpga_clkratio_ctrl.sv
// APB-programmable clock-ratio controller with glitch-free ratio switching.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   RUN    | normal division at cur_ratio; RATIO writes accepted
//   DRAIN  | finishing the current period before adopting pend_ratio
//   SETTLE | clk_en held low for SETTLE_CYC cycles after the switch
module fpga_clkratio_ctrl
  import fpga_clk_pkg::*;
#(
  parameter int RATIO_W    = 3,
  parameter int SETTLE_CYC = 4,
  parameter int RST_RATIO  = 0
) (
  input  logic               per_clk,
  input  logic               clkrst,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [3:0]         paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic               gate_en0,
  input  logic               gate_en1,
  output logic               clk_en,
  output logic [RATIO_W-1:0] cur_ratio,
  output logic               ratio_busy
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [RATIO_W-1:0] RST_VAL     = RATIO_W'(RST_RATIO);

  state_t               state_q, state_d;
  logic [RATIO_W-1:0]   cur_q, cur_d;
  logic [RATIO_W-1:0]   pend_q, pend_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic                 gate_q;
  logic [RATIO_W-1:0]   cnt;
  logic                 wrap;
  logic                 run;
  logic                 acc;
  logic [1:0]           idx;
  logic                 wr_ratio;
  logic [RATIO_W-1:0]   wr_val;
  logic [31:0]          status_word;
  logic                 unused_bits;

  assign acc      = psel & penable;
  assign idx      = paddr[3:2];
  assign wr_val   = pwdata[RATIO_W-1:0];
  assign wr_ratio = acc & pwrite & (idx == REG_RATIO) & (state_q == RUN);
  assign run      = (state_q == RUN) | (state_q == DRAIN);

  assign unused_bits = ^{pwdata[31:RATIO_W], paddr[1:0]};

  fpga_clk_div_cnt #(.RATIO_W(RATIO_W)) u_div_cnt (
    .per_clk   (per_clk),
    .clkrst    (clkrst),
    .run       (run),
    .gate_q    (gate_q),
    .cur_ratio (cur_q),
    .cnt       (cnt),
    .wrap      (wrap)
  );

  assign clk_en     = wrap;
  assign cur_ratio  = cur_q;
  assign ratio_busy = (state_q != RUN);
  assign pready     = 1'b1;

  // Errors: writes to read-only words, anything at the unmapped word,
  // and RATIO writes while a switch is still in flight
  assign pslverr = acc & ((idx == 2'd3) |
                          (pwrite & ((idx != REG_RATIO) | (state_q != RUN))));

  // Assemble the STATUS word
  always_comb begin
    status_word                               = '0;
    status_word[ST_BUSY_BIT]                  = ratio_busy;
    status_word[ST_CUR_LSB +: RATIO_W]        = cur_q;
    status_word[ST_PEND_LSB +: RATIO_W]       = pend_q;
    status_word[ST_GATE_BIT]                  = gate_q;
  end

  // Read mux, driven only during a read access
  always_comb begin
    prdata = '0;
    if (acc && !pwrite) begin
      case (idx)
        REG_RATIO:  prdata[RATIO_W-1:0] = pend_q;
        REG_STATUS: prdata              = status_word;
        REG_CNT:    prdata[RATIO_W-1:0] = cnt;
        default:    prdata              = '0;
      endcase
    end
  end

  // Ratio-switch sequencing
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    pend_d   = pend_q;
    settle_d = settle_q;
    case (state_q)
      RUN: begin
        if (wr_ratio) begin
          pend_d = wr_val;
          if (wr_val != cur_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // wrap means the final pulse of the old period is out this cycle
        if (wrap || gate_q) begin
          state_d  = SETTLE;
          cur_d    = pend_q;
          settle_d = '0;
        end
      end
      SETTLE: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == SETTLE_LAST) begin
          state_d  = RUN;
          settle_d = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, ratio and gate registers
  always_ff @(posedge per_clk) begin
    if (clkrst) begin
      state_q  <= RUN;
      cur_q    <= RST_VAL;
      pend_q   <= RST_VAL;
      settle_q <= '0;
      gate_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      pend_q   <= pend_d;
      settle_q <= settle_d;
      gate_q   <= gate_en0 | gate_en1;
    end
  end

endmodule

// File: tb/tb_fpga_clkratio_ctrl.sv
// Self-checking bench for fpga_clkratio_ctrl: directed scenarios with
// literal expectations plus randomized APB/gate traffic against a model.
module tb_fpga_clkratio_ctrl;

  localparam int RATIO_W    = 3;
  localparam int SETTLE_CYC = 4;
  localparam int RST_RATIO  = 0;
  localparam int RMASK      = (1 << RATIO_W) - 1;

  logic               per_clk  = 1'b0;
  logic               clkrst   = 1'b1;
  logic               psel     = 1'b0;
  logic               penable  = 1'b0;
  logic               pwrite   = 1'b0;
  logic [3:0]         paddr    = '0;
  logic [31:0]        pwdata   = '0;
  logic               gate_en0 = 1'b0;
  logic               gate_en1 = 1'b0;
  logic [31:0]        prdata;
  logic               pready;
  logic               pslverr;
  logic               clk_en;
  logic [RATIO_W-1:0] cur_ratio;
  logic               ratio_busy;

  always #5 per_clk = ~per_clk;

  fpga_clkratio_ctrl #(
    .RATIO_W(RATIO_W), .SETTLE_CYC(SETTLE_CYC), .RST_RATIO(RST_RATIO)
  ) dut (
    .per_clk(per_clk), .clkrst(clkrst),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .gate_en0(gate_en0), .gate_en1(gate_en1),
    .clk_en(clk_en), .cur_ratio(cur_ratio), .ratio_busy(ratio_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = running, 1 = draining old period, 2 = settling
  bit m_valid   = 0;
  int m_phase   = 0;
  int m_cur     = RST_RATIO;
  int m_pend    = RST_RATIO;
  int m_elapsed = 0;   // cycles into the current period
  int m_left    = 0;   // settle cycles still to go
  bit m_gate    = 0;

  task automatic model_step();
    bit acc, wr_ok, period_end;
    if (clkrst) begin
      m_valid = 1; m_phase = 0; m_cur = RST_RATIO; m_pend = RST_RATIO;
      m_elapsed = 0; m_left = 0; m_gate = 0;
      return;
    end
    if (!m_valid) return;
    acc        = psel && penable;
    wr_ok      = acc && pwrite && (paddr[3:2] == 2'd0) && (m_phase == 0);
    period_end = m_gate || (m_elapsed == m_cur);
    case (m_phase)
      0: begin
        m_elapsed = period_end ? 0 : m_elapsed + 1;
        if (wr_ok) begin
          m_pend = int'(pwdata) & RMASK;
          if (m_pend != m_cur) m_phase = 1;
        end
      end
      1: begin
        if (period_end) begin
          m_phase = 2; m_cur = m_pend; m_elapsed = 0; m_left = SETTLE_CYC;
        end else begin
          m_elapsed = m_elapsed + 1;
        end
      end
      default: begin
        m_elapsed = 0;
        m_left    = m_left - 1;
        if (m_left == 0) m_phase = 0;
      end
    endcase
    m_gate = gate_en0 | gate_en1;
  endtask

  function automatic logic [31:0] exp_rdata();
    logic [31:0] r;
    r = 0;
    if (psel && penable && !pwrite) begin
      case (paddr[3:2])
        2'd0: r = m_pend;
        2'd1: r = (m_phase != 0 ? 1 : 0) | (m_cur << 4) | (m_pend << 8) | (int'(m_gate) << 12);
        2'd2: r = m_elapsed;
        default: r = 0;
      endcase
    end
    return r;
  endfunction

  function automatic logic exp_err();
    if (!(psel && penable)) return 1'b0;
    if (paddr[3:2] == 2'd3) return 1'b1;
    return pwrite && (paddr[3:2] != 2'd0 || m_phase != 0);
  endfunction

  initial forever begin
    @(posedge per_clk);
    model_step();
  end

  // Compare every cycle, half a period after the edge
  initial forever begin
    @(negedge per_clk);
    if (m_valid) begin
      chk("clk_en",     clk_en, (m_phase != 2) && !m_gate && (m_elapsed == m_cur));
      chk("cur_ratio",  cur_ratio, m_cur);
      chk("ratio_busy", ratio_busy, m_phase != 0);
      chk("prdata",     prdata, exp_rdata());
      chk("pslverr",    pslverr, exp_err());
      chk("pready",     pready, 1'b1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apb(input bit wr, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    @(posedge per_clk); #1;
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge per_clk); #1;
    penable = 1;
    @(negedge per_clk);
    rd = prdata; err = pslverr;
    @(posedge per_clk); #1;
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic do_reset();
    @(posedge per_clk); #1 clkrst = 1;
    @(posedge per_clk); #1 clkrst = 0;
  endtask

  // Counts busy negedges until ratio_busy drops; returns -1 on timeout
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge per_clk);
      if (!ratio_busy) return;
      n++;
    end
    n = -1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [7:0]  pat;
    int          n;

    repeat (3) @(posedge per_clk);
    #1 clkrst = 0;

    // 1: reset state, ratio 0 pulses every cycle
    @(negedge per_clk);
    chk("t1_clk_en", clk_en, 1);
    chk("t1_busy", ratio_busy, 0);
    apb(0, 4'h4, 0, rd, err);
    chk("t1_status", rd, 32'h0);
    chk("t1_err", err, 0);

    // 2: switch to ratio 3
    apb(1, 4'h0, 32'd3, rd, err);
    chk("t2_wr_err", err, 0);
    @(negedge per_clk);
    chk("t2_drain_busy", ratio_busy, 1);
    chk("t2_drain_pulse", clk_en, 1);
    count_busy(n);
    chk("t2_settle_len", n, SETTLE_CYC);
    pat = {7'b0, clk_en};
    repeat (7) begin
      @(negedge per_clk);
      pat = {pat[6:0], clk_en};
    end
    chk("t2_run_pattern", pat, 8'b0001_0001);
    apb(0, 4'h4, 0, rd, err);
    chk("t2_status", rd, 32'h330);

    // 3: RATIO write during SETTLE is rejected
    do_reset();
    apb(1, 4'h0, 32'd3, rd, err);
    apb(1, 4'h0, 32'd5, rd, err);
    chk("t3_busy_wr_err", err, 1);
    apb(0, 4'h0, 0, rd, err);
    chk("t3_pend_kept", rd, 3);
    count_busy(n);
    chk("t3_switch_done", n >= 0, 1);
    apb(0, 4'h4, 0, rd, err);
    chk("t3_status", rd, 32'h330);

    // 4: gate for 6 cycles at ratio 3
    @(posedge per_clk); #1 gate_en0 = 1;
    repeat (6) @(posedge per_clk);
    #1 gate_en0 = 0;
    n = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge per_clk);
      if (clk_en) begin n = i; break; end
    end
    chk("t4_first_pulse", n, 5);

    // 5: gated switch to ratio 1
    @(posedge per_clk); #1 gate_en1 = 1;
    repeat (2) @(posedge per_clk);
    #1;
    apb(1, 4'h0, 32'd1, rd, err);
    count_busy(n);
    chk("t5_busy_len", n, 1 + SETTLE_CYC);
    @(posedge per_clk); #1 gate_en1 = 0;
    pat = '0;
    repeat (5) begin
      @(negedge per_clk);
      pat = {pat[6:0], clk_en};
    end
    chk("t5_toggle", pat, 8'b0000_0101);

    // 6: unmapped word, then reset mid-switch
    apb(1, 4'hC, 32'hFFFF_FFFF, rd, err);
    chk("t6_wr_c_err", err, 1);
    apb(0, 4'hC, 0, rd, err);
    chk("t6_rd_c_data", rd, 0);
    chk("t6_rd_c_err", err, 1);
    apb(1, 4'h0, 32'd5, rd, err);
    repeat (2) @(posedge per_clk);
    @(negedge per_clk);
    chk("t6_in_switch", ratio_busy, 1);
    @(posedge per_clk); #1 clkrst = 1;
    @(posedge per_clk); #1 clkrst = 0;
    @(negedge per_clk);
    chk("t6_rst_busy", ratio_busy, 0);
    chk("t6_rst_ratio", cur_ratio, RST_RATIO);
    chk("t6_rst_clk_en", clk_en, 1);

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_reset();
      end else if (r < 55) begin
        logic [3:0]  a;
        logic [31:0] d;
        a = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
        d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, RMASK));
        apb(1'($urandom_range(0, 1)), a, d, rd, err);
      end else begin
        @(posedge per_clk); #1;
        gate_en0 = ($urandom_range(0, 9) == 0);
        gate_en1 = ($urandom_range(0, 14) == 0);
        repeat ($urandom_range(0, 6)) @(posedge per_clk);
        #1;
      end
    end
    gate_en0 = 0;
    gate_en1 = 0;
    repeat (20) @(posedge per_clk);
    @(negedge per_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
